// File: rtl/b_onehot_pulse_decoder_pkg.sv
// b_onehot_pulse_decoder_pkg: shared state encoding and default parameters for the one-hot pulse decoder
package b_onehot_pulse_decoder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;
    localparam int DEF_WIDTH_IN = 3;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_HOLD     = 2;
    localparam int DEF_GAP      = 1;
endpackage

// File: rtl/b_onehot_pulse_decoder_fifo.sv
// b_code_fifo: small circular FIFO buffering accepted codes, count carries one extra bit for full
module b_code_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/b_onehot_pulse_decoder.sv
// b_onehot_pulse_decoder: replays buffered codes as one-hot pulses of HOLD cycles separated by GAP idle cycles
module b_onehot_pulse_decoder
    import b_onehot_pulse_decoder_pkg::*;
#(
    parameter int WIDTH_IN = DEF_WIDTH_IN,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int HOLD     = DEF_HOLD,
    parameter int GAP      = DEF_GAP,
    localparam int WIDTH_OUT = 1 << WIDTH_IN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_IN-1:0]  code,
    output logic [WIDTH_OUT-1:0] q,
    output logic                 out_valid,
    output logic                 busy
);
    localparam int CMAX  = HOLD > GAP ? HOLD : GAP;
    localparam int CNT_W = CMAX > 1 ? $clog2(CMAX) : 1;
    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [WIDTH_OUT-1:0] q_d;
    logic [WIDTH_IN-1:0]  head;
    logic                 full, empty, push, pop, load, drive_end;
    logic [$clog2(DEPTH):0] count;
    b_code_fifo #(.WIDTH(WIDTH_IN), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (code),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            q     <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            q     <= q_d;
        end
    end
    // load marks every edge where the next code may start; with GAP=0 that includes the last DRIVE cycle
    always_comb begin
        drive_end = state == ST_DRIVE && cnt == '0;
        load      = state == ST_IDLE || (state == ST_GAP && cnt == '0) || (drive_end && GAP == 0);
        pop       = load && !empty;
        state_d   = pop ? ST_DRIVE : load ? ST_IDLE : drive_end ? ST_GAP : state;
        cnt_d     = pop ? CNT_W'(HOLD - 1)
                  : drive_end ? (GAP > 0 ? CNT_W'(GAP - 1) : '0)
                  : cnt != '0 ? cnt - 1'b1 : '0;
        q_d       = pop ? WIDTH_OUT'(1) << head : (load || drive_end) ? '0 : q;
    end
    always_comb begin
        out_valid = |q;
        busy      = state != ST_IDLE || count != '0;
    end
endmodule

// File: tb/tb_b_onehot_pulse_decoder.sv
// tb_b_onehot_pulse_decoder: scoreboard bench for the default decoder plus a HOLD=1/GAP=0 instance
module tb_b_onehot_pulse_decoder;
    localparam int HOLD = 2;
    logic       clk = 0, rst;
    logic       in_valid, in_ready, out_valid, busy;
    logic [2:0] code;
    logic [7:0] q;
    logic       in_valid0, in_ready0, out_valid0, busy0;
    logic [2:0] code0;
    logic [7:0] q0;
    int vectors = 0, errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur;
    int run = 0;

    b_onehot_pulse_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .code(code), .q(q), .out_valid(out_valid), .busy(busy)
    );
    b_onehot_pulse_decoder #(.HOLD(1), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .code(code0), .q(q0), .out_valid(out_valid0), .busy(busy0)
    );

    always #5 clk = ~clk;

    // producer side of the scoreboard: every accepted code becomes an expected pulse
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) exp_q.push_back(8'd1 << code);
    end

    // consumer side: each pulse is HOLD cycles of the next expected one-hot value
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            run = 0;
        end else begin
            vectors++;
            if (out_valid !== (q != 8'd0)) begin
                errors++;
                $display("FAIL out_valid_track: out_valid=%b q=%h", out_valid, q);
            end
            if (out_valid) begin
                if (run == 0) begin
                    if (exp_q.size() == 0) begin
                        cur = 8'd0;
                        errors++;
                        $display("FAIL unexpected_pulse: got q=%h, expected nothing", q);
                    end else cur = exp_q.pop_front();
                end
                vectors++;
                if (q !== cur) begin
                    errors++;
                    $display("FAIL pulse_value: got q=%h, expected %h (cycle %0d of pulse)", q, cur, run);
                end
                run = (run + 1 == HOLD) ? 0 : run + 1;
            end else if (run != 0) begin
                vectors++;
                errors++;
                $display("FAIL pulse_short: q dropped after %0d cycles, expected %0d", run, HOLD);
                run = 0;
            end
        end
    end

    // drives one code and holds it until accepted; returns at the negedge after acceptance
    task automatic send(input logic [2:0] c, output logic ok, output int stalls);
        logic r;
        ok = 0;
        stalls = 0;
        in_valid = 1;
        code = c;
        for (int n = 0; n < 50 && !ok; n++) begin
            r = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) ok = 1;
            else stalls++;
        end
        in_valid = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: busy=%b after %0d cycles, expected 0", name, busy, n);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: %0d pulses never emitted, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic saw = 0;
        rst = 1;
        in_valid = 1;
        code = 3'd5;
        repeat (3) @(negedge clk);
        vectors++;
        if (q !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: q=%h out_valid=%b busy=%b, expected 00 0 0", q, out_valid, busy);
        end
        in_valid = 0;
        rst = 0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b, expected 1 0", in_ready, busy);
        end
        repeat (8) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        vectors++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL reset_ghost: pulse seen=%b for code held in reset, expected 0", saw);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_seq [5] = '{8'h00, 8'h08, 8'h08, 8'h00, 8'h00};
        logic       exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        in_valid = 1;
        code = 3'd3;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: in_ready=%b, expected 1", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 0;
            vectors++;
            if (q !== exp_seq[i] || busy !== exp_busy[i]) begin
                errors++;
                $display("FAIL single_edge_k+%0d: q=%h busy=%b, expected %h %b", i, q, busy, exp_seq[i], exp_busy[i]);
            end
        end
        drain("single");
    endtask

    task automatic test_sweep();
        logic ok;
        int st, total = 0, ok_cnt = 0;
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            send(3'(c), ok, st);
            total += st;
            if (ok) ok_cnt++;
        end
        vectors++;
        if (ok_cnt != 8) begin
            errors++;
            $display("FAIL sweep_accept: %0d codes accepted, expected 8", ok_cnt);
        end
        vectors++;
        if (total == 0) begin
            errors++;
            $display("FAIL sweep_backpressure: %0d stall cycles, expected in_ready to drop at least once", total);
        end
        drain("sweep");
    endtask

    task automatic test_full();
        logic ok;
        int st, st7 = 0;
        @(negedge clk);
        for (int c = 1; c <= 7; c++) begin
            send(3'(c), ok, st);
            if (c == 7) st7 = st;
            if (c == 6) begin
                vectors++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL full_ready: in_ready=%b busy=%b after 6 codes, expected 0 1", in_ready, busy);
                end
            end
        end
        vectors++;
        if (st7 == 0 || !ok) begin
            errors++;
            $display("FAIL full_hold: 7th code stalls=%0d accepted=%b, expected stalls>0 and accepted", st7, ok);
        end
        drain("full");
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [3] = '{3'd6, 3'd6, 3'd1};
        logic [7:0] exp_seq [4] = '{8'h40, 8'h40, 8'h02, 8'h00};
        @(negedge clk);
        in_valid0 = 1;
        for (int i = 0; i < 5; i++) begin
            code0 = i < 3 ? codes[i] : 3'd0;
            in_valid0 = i < 3;
            vectors++;
            if (i < 3 && in_ready0 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: in_ready=%b, expected 1", i, in_ready0);
            end
            @(posedge clk);
            @(negedge clk);
            if (i > 0) begin
                vectors++;
                if (q0 !== exp_seq[i-1] || out_valid0 !== (exp_seq[i-1] != 8'h00)) begin
                    errors++;
                    $display("FAIL b2b_edge_k+%0d: q=%h out_valid=%b, expected %h", i, q0, out_valid0, exp_seq[i-1]);
                end
            end
        end
        in_valid0 = 0;
        @(negedge clk);
        vectors++;
        if (busy0 !== 1'b0 || q0 !== 8'h00) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b q=%h, expected 0 00", busy0, q0);
        end
    endtask

    task automatic test_mid_reset();
        logic ok, saw = 0;
        int st;
        @(negedge clk);
        send(3'd4, ok, st);
        send(3'd1, ok, st);
        send(3'd2, ok, st);
        vectors++;
        if (q !== 8'h10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup: q=%h busy=%b, expected 10 1", q, busy);
        end
        #2 rst = 1;
        #1;
        vectors++;
        if (q !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async: q=%h out_valid=%b busy=%b in_ready=%b, expected 00 0 0 1", q, out_valid, busy, in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        vectors++;
        if (saw !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flush: pulse seen=%b busy=%b after release, expected 0 0", saw, busy);
        end
    endtask

    initial begin
        rst = 1;
        in_valid = 0;
        code = '0;
        in_valid0 = 0;
        code0 = '0;
        test_reset();
        test_single();
        test_sweep();
        test_full();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
